program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory_pkg.sv | 19 +
 rtl/sdp_ram.sv | 31 +++
 rtl/program_memory.sv | 132 +++++++++++++
 tb/tb_program_memory.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory: NOP opcode, FSM state encoding
// and a pointer-width helper.
package program_memory_pkg;

    localparam int unsigned OPCODE_WIDTH = 8;
    localparam logic [OPCODE_WIDTH-1:0] NOP_OPCODE = 8'hEA;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Bits needed to address DEPTH words; never less than one.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds
// its output when no read is requested. The array has no reset.
module sdp_ram #(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_memory.sv
// Instruction store: wiped to NOPs after reset, loaded by a streaming
// write port, fetched with one cycle of latency.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iFetch,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    output logic                  oFault,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadAddr,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iLoadValid,
    input  logic                  iLoadLast,
    output logic                  oLoadReady,
    output logic                  oBusy
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD =
        DATA_WIDTH'(NOP_OPCODE) << (DATA_WIDTH - OPCODE_WIDTH);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              sel_ram_q, sel_ram_d;

    logic                  ram_we;
    logic [PTR_W-1:0]      ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  addr_oob;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            wptr_q    <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            sel_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wptr_q    <= wptr_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            sel_ram_q <= sel_ram_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wptr_d    = wptr_q;
        ram_we    = 1'b0;
        ram_waddr = wptr_q;
        ram_wdata = iLoadData;

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = NOP_WORD;
                if (clr_cnt_q == LAST_PTR) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (iLoadStart) begin
                    state_d = ST_LOAD;
                    wptr_d  = PTR_W'(32'(iLoadAddr) % DEPTH);
                end
            end
            ST_LOAD: begin
                if (iLoadValid) begin
                    ram_we = 1'b1;
                    wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
                    if (iLoadLast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Fetch path: only an in-range fetch in IDLE reads the array.
        addr_oob  = (32'(iAddress) >= DEPTH);
        ram_re    = iFetch && (state_q == ST_IDLE) && !addr_oob;
        valid_d   = iFetch;
        fault_d   = iFetch && addr_oob;
        sel_ram_d = iFetch ? ram_re : sel_ram_q;
    end

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PTR_W)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (iAddress[PTR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // RAM output register holds between fetches, so the selected word persists.
    assign oInstruction = sel_ram_q ? ram_rdata : NOP_WORD;
    assign oValid       = valid_q;
    assign oFault       = fault_q;
    assign oLoadReady   = (state_q == ST_LOAD);
    assign oBusy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_program_memory.sv
// Directed plus randomized bench for program_memory against an array model.
module tb_program_memory;

    localparam int unsigned DW    = 28;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam logic [DW-1:0] NOP_W = {program_memory_pkg::NOP_OPCODE, 20'h0};

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [AW-1:0] iAddress = '0;
    logic          iFetch = 1'b0;
    logic [DW-1:0] oInstruction;
    logic          oValid, oFault;
    logic          iLoadStart = 1'b0;
    logic [AW-1:0] iLoadAddr = '0;
    logic [DW-1:0] iLoadData = '0;
    logic          iLoadValid = 1'b0;
    logic          iLoadLast = 1'b0;
    logic          oLoadReady, oBusy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_instr;

    program_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iAddress     (iAddress),
        .iFetch       (iFetch),
        .oInstruction (oInstruction),
        .oValid       (oValid),
        .oFault       (oFault),
        .iLoadStart   (iLoadStart),
        .iLoadAddr    (iLoadAddr),
        .iLoadData    (iLoadData),
        .iLoadValid   (iLoadValid),
        .iLoadLast    (iLoadLast),
        .oLoadReady   (oLoadReady),
        .oBusy        (oBusy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wipe_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP_W;
        exp_instr = NOP_W;
    endtask

    // One clock; checks the fetch outputs for whatever fetch was presented.
    task automatic tick(input bit busy, input string tag);
        logic          f;
        logic [AW-1:0] a;
        f = iFetch;
        a = iAddress;
        @(posedge Clock);
        #1;
        if (f) begin
            exp_instr = (busy || a >= DEPTH) ? NOP_W : mem_m[a];
            check({tag, "_valid"}, oValid, 1);
            check({tag, "_fault"}, oFault, (a >= DEPTH) ? 1 : 0);
        end else begin
            check({tag, "_novalid"}, oValid, 0);
            check({tag, "_nofault"}, oFault, 0);
        end
        check({tag, "_instr"}, oInstruction, exp_instr);
        iFetch = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input string tag);
        iFetch   = 1'b1;
        iAddress = a;
        tick(1'b0, tag);
    endtask

    // Count busy cycles after reset release; optionally pokes iLoadStart during CLEAR.
    task automatic wait_clear(input bit poke, input string tag);
        int n;
        n = 0;
        if (poke) begin
            iLoadStart = 1'b1;
            iLoadAddr  = 16'd9;
        end
        while (oBusy === 1'b1 && n < 1000) begin
            @(posedge Clock);
            #1;
            n++;
            if (n == 10) iLoadStart = 1'b0;
        end
        iLoadStart = 1'b0;
        check({tag, "_busy_cycles"}, n, DEPTH);
        check({tag, "_ready_idle"}, oLoadReady, 0);
    endtask

    // Stream a program load; random gaps and random fetches while loading.
    task automatic do_load(input logic [AW-1:0] start, input logic [DW-1:0] words[$],
                           input bit gaps, input string tag);
        int p;
        int g;
        p = int'(start) % DEPTH;
        iLoadStart = 1'b1;
        iLoadAddr  = start;
        tick(1'b0, {tag, "_start"});
        iLoadStart = 1'b0;
        check({tag, "_ready"}, oLoadReady, 1);
        check({tag, "_busy"}, oBusy, 1);
        for (int i = 0; i < words.size(); i++) begin
            g = 0;
            while (gaps && g < 3 && $urandom_range(0, 2) == 0) begin
                iLoadValid = 1'b0;
                iFetch     = 1'($urandom_range(0, 1));
                iAddress   = 16'($urandom_range(0, 319));
                tick(1'b1, {tag, "_gap"});
                check({tag, "_gap_ready"}, oLoadReady, 1);
                g++;
            end
            iLoadValid = 1'b1;
            iLoadData  = words[i];
            iLoadLast  = (i == words.size() - 1);
            iFetch     = 1'($urandom_range(0, 1));
            iAddress   = 16'($urandom_range(0, 319));
            tick(1'b1, {tag, "_beat"});
            mem_m[p] = words[i];
            p = (p + 1) % DEPTH;
        end
        iLoadValid = 1'b0;
        iLoadLast  = 1'b0;
        check({tag, "_done_busy"}, oBusy, 0);
        check({tag, "_done_ready"}, oLoadReady, 0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        wipe_model();

        // Reset values while held
        repeat (3) @(posedge Clock);
        #1;
        check("rst_instr", oInstruction, NOP_W);
        check("rst_valid", oValid, 0);
        check("rst_fault", oFault, 0);
        check("rst_ready", oLoadReady, 0);
        check("rst_busy", oBusy, 1);
        Reset = 1'b1;
        wait_clear(1'b1, "clear0");

        fetch(16'd37, "f37");
        check("f37_nop", oInstruction, NOP_W);
        tick(1'b0, "hold0");

        // Three-word load at 4
        q = '{28'h1000001, 28'h2000002, 28'h3000003};
        do_load(16'd4, q, 1'b0, "ld4");
        fetch(16'd4, "f4");
        check("f4_word", oInstruction, 28'h1000001);
        fetch(16'd5, "f5");
        check("f5_word", oInstruction, 28'h2000002);
        fetch(16'd6, "f6");
        check("f6_word", oInstruction, 28'h3000003);
        tick(1'b0, "hold6");
        check("hold6_word", oInstruction, 28'h3000003);
        fetch(16'd7, "f7");
        check("f7_nop", oInstruction, NOP_W);

        // Wrap from the last address
        q = '{28'hABCDE01, 28'h5A5A5A5};
        do_load(16'd255, q, 1'b0, "ldwrap");
        fetch(16'd255, "f255");
        check("f255_word", oInstruction, 28'hABCDE01);
        fetch(16'd0, "f0");
        check("f0_wrapword", oInstruction, 28'h5A5A5A5);

        // Out of range fetch
        fetch(16'd300, "f300");
        check("f300_nop", oInstruction, NOP_W);
        check("f300_fault", oFault, 1);
        tick(1'b0, "after300");

        // Valid toggled 1,0,1
        iLoadStart = 1'b1;
        iLoadAddr  = 16'd20;
        tick(1'b0, "tg_start");
        iLoadStart = 1'b0;
        iLoadValid = 1'b1;
        iLoadData  = 28'h0111111;
        tick(1'b1, "tg_w0");
        mem_m[20] = 28'h0111111;
        iLoadValid = 1'b0;
        iLoadData  = 28'h0999999;
        tick(1'b1, "tg_gap");
        check("tg_gap_ready", oLoadReady, 1);
        iLoadValid = 1'b1;
        iLoadLast  = 1'b1;
        iLoadData  = 28'h0222222;
        tick(1'b1, "tg_w1");
        mem_m[21] = 28'h0222222;
        iLoadValid = 1'b0;
        iLoadLast  = 1'b0;
        check("tg_idle", oBusy, 0);
        fetch(16'd20, "tg_f20");
        check("tg_f20_word", oInstruction, 28'h0111111);
        fetch(16'd21, "tg_f21");
        check("tg_f21_word", oInstruction, 28'h0222222);
        fetch(16'd22, "tg_f22");
        check("tg_f22_nop", oInstruction, NOP_W);

        // Randomized loads and back-to-back fetches
        for (int k = 0; k < 6; k++) begin
            q = {};
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) q.push_back(28'($urandom));
            do_load(16'($urandom), q, 1'b1, "rld");
            for (int j = 0; j < 12; j++) fetch(16'($urandom_range(0, 319)), "rf");
        end

        // Reset mid-load after two of five words
        iLoadStart = 1'b1;
        iLoadAddr  = 16'd10;
        tick(1'b0, "ml_start");
        iLoadStart = 1'b0;
        iLoadValid = 1'b1;
        iLoadData  = 28'h7000001;
        tick(1'b1, "ml_w0");
        iLoadData  = 28'h7000002;
        iFetch     = 1'b1;
        iAddress   = 16'd3;
        tick(1'b1, "ml_w1");
        iLoadValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        wipe_model();
        check("ml_rst_instr", oInstruction, NOP_W);
        check("ml_rst_valid", oValid, 0);
        check("ml_rst_fault", oFault, 0);
        check("ml_rst_ready", oLoadReady, 0);
        check("ml_rst_busy", oBusy, 1);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        wait_clear(1'b0, "clear1");
        fetch(16'd10, "ml_f10");
        check("ml_f10_nop", oInstruction, NOP_W);
        fetch(16'd11, "ml_f11");
        check("ml_f11_nop", oInstruction, NOP_W);
        fetch(16'd4, "ml_f4");
        check("ml_f4_nop", oInstruction, NOP_W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
